dmem_store_buffer: RTL and testbench



---
 rtl/dmem_store_buffer.sv | 134 +++++++++++++
 tb/tb_dmem_store_buffer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_store_buffer.sv
// Posted-store FIFO between the pipeline memory stage and data_mem.
// Stores retire into the buffer; loads pass through unless they hit a buffered word.
module dmem_store_buffer #(
  parameter int DEPTH          = 4,
  parameter int LOG2DEPTH      = 2,
  parameter int D_ADDRESSWIDTH = 32,
  parameter int DM_DATAWIDTH   = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      en,
  input  logic [3:0]                op,
  input  logic [D_ADDRESSWIDTH-1:0] d_address,
  input  logic [DM_DATAWIDTH-1:0]   d_writedata,
  output logic                      stalled,
  output logic                      mem_en,
  output logic [3:0]                mem_op,
  output logic [D_ADDRESSWIDTH-1:0] mem_address,
  output logic [DM_DATAWIDTH-1:0]   mem_writedata,
  input  logic                      mem_stalled,
  output logic                      sb_empty,
  output logic [LOG2DEPTH:0]        sb_count
);

  localparam logic [LOG2DEPTH:0] FULL_CNT = (LOG2DEPTH+1)'(DEPTH);

  logic [D_ADDRESSWIDTH-1:0] addr_q [DEPTH];
  logic [D_ADDRESSWIDTH-1:0] addr_d [DEPTH];
  logic [DM_DATAWIDTH-1:0]   data_q [DEPTH];
  logic [DM_DATAWIDTH-1:0]   data_d [DEPTH];
  logic [1:0]                size_q [DEPTH];
  logic [1:0]                size_d [DEPTH];
  logic [LOG2DEPTH-1:0]      head_q, head_d;
  logic [LOG2DEPTH-1:0]      tail_q, tail_d;
  logic [LOG2DEPTH:0]        count_q, count_d;
  logic [LOG2DEPTH-1:0]      idx;
  logic                      full, empty, hazard, push, pop;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign sb_empty = empty;
  assign sb_count = count_q;

  // Word-granular match against every occupied slot, walking from the head.
  always_comb begin
    hazard = 1'b0;
    idx    = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + LOG2DEPTH'(k);
      if (((LOG2DEPTH+1)'(k) < count_q) &&
          (addr_q[idx][D_ADDRESSWIDTH-1:2] == d_address[D_ADDRESSWIDTH-1:2]))
        hazard = 1'b1;
    end
  end

  // Cycle decode: a push never coincides with a pop, so the port is never contended.
  always_comb begin
    push          = 1'b0;
    pop           = 1'b0;
    stalled       = 1'b0;
    mem_en        = 1'b0;
    mem_op        = '0;
    mem_address   = '0;
    mem_writedata = '0;
    if (resetn) begin
      if (en && op[3]) begin
        if (!full) begin
          push = 1'b1;
        end else begin
          stalled = 1'b1;
          pop     = 1'b1;
        end
      end else if (en) begin
        if (hazard) begin
          stalled = 1'b1;
          pop     = 1'b1;
        end else begin
          mem_en      = 1'b1;
          mem_op      = op;
          mem_address = d_address;
          stalled     = mem_stalled;
        end
      end else begin
        pop = !empty;
      end
      if (pop) begin
        mem_en        = 1'b1;
        mem_op        = {2'b10, size_q[head_q]};
        mem_address   = addr_q[head_q];
        mem_writedata = data_q[head_q];
      end
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    if (push) begin
      addr_d[tail_q] = d_address;
      data_d[tail_q] = d_writedata;
      size_d[tail_q] = op[1:0];
      tail_d         = tail_q + 1'b1;
      count_d        = count_q + 1'b1;
    end
    if (pop) begin
      head_d  = head_q + 1'b1;
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload needs no reset: occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    size_q <= size_d;
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: directed scenarios plus random traffic against a queue model.
module tb_dmem_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        en;
  logic [3:0]  op;
  logic [31:0] d_address;
  logic [31:0] d_writedata;
  logic        stalled;
  logic        mem_en;
  logic [3:0]  mem_op;
  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic        mem_stalled;
  logic        sb_empty;
  logic [2:0]  sb_count;

  dmem_store_buffer #(.DEPTH(4), .LOG2DEPTH(2), .D_ADDRESSWIDTH(32), .DM_DATAWIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .en(en), .op(op), .d_address(d_address),
    .d_writedata(d_writedata), .stalled(stalled), .mem_en(mem_en), .mem_op(mem_op),
    .mem_address(mem_address), .mem_writedata(mem_writedata), .mem_stalled(mem_stalled),
    .sb_empty(sb_empty), .sb_count(sb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] w;
    logic [1:0]  sz;
  } ent_t;

  ent_t q[$];
  int checks   = 0;
  int failures = 0;

  // Outputs observed in the most recent cycle, and in the first cycle of the last issue.
  logic        o_en, o_st, f_en;
  logic [3:0]  o_op, f_op;
  logic [31:0] o_addr, o_wd, f_addr, f_wd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, compare combinational outputs, then advance the model.
  task automatic cyc(input logic e, input logic [3:0] o, input logic [31:0] a,
                     input logic [31:0] w, input logic ms, output logic st);
    logic        x_en, x_st, haz, pop, push;
    logic [3:0]  x_op;
    logic [31:0] x_a, x_w;
    @(negedge clk);
    chk("sb_count", 64'(sb_count), 64'(q.size()));
    chk("sb_empty", 64'(sb_empty), 64'(q.size() == 0));
    en = e; op = o; d_address = a; d_writedata = w; mem_stalled = ms;
    #1;
    x_en = 0; x_st = 0; x_op = 0; x_a = 0; x_w = 0; pop = 0; push = 0;
    if (e && o[3]) begin
      if (q.size() < DEPTH) push = 1;
      else begin x_st = 1; pop = 1; end
    end else if (e) begin
      haz = 0;
      foreach (q[i]) if (q[i].a[31:2] == a[31:2]) haz = 1;
      if (haz) begin x_st = 1; pop = 1; end
      else begin x_en = 1; x_op = o; x_a = a; x_st = ms; end
    end else if (q.size() > 0) begin
      pop = 1;
    end
    if (pop) begin
      x_en = 1; x_op = {2'b10, q[0].sz}; x_a = q[0].a; x_w = q[0].w;
    end
    chk("stalled",       64'(stalled),       64'(x_st));
    chk("mem_en",        64'(mem_en),        64'(x_en));
    chk("mem_op",        64'(mem_op),        64'(x_op));
    chk("mem_address",   64'(mem_address),   64'(x_a));
    chk("mem_writedata", 64'(mem_writedata), 64'(x_w));
    o_en = mem_en; o_op = mem_op; o_addr = mem_address; o_wd = mem_writedata; o_st = stalled;
    st = stalled;
    if (pop) void'(q.pop_front());
    if (push) q.push_back('{a: a, w: w, sz: o[1:0]});
  endtask

  // Present a request and hold it while stalled; nst counts the stall cycles seen.
  task automatic issue(input logic e, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] w, input logic ms, output int nst);
    logic st;
    nst = 0;
    cyc(e, o, a, w, ms, st);
    f_en = o_en; f_op = o_op; f_addr = o_addr; f_wd = o_wd;
    while (st && nst < 16) begin
      nst++;
      cyc(e, o, a, w, 1'b0, st);
    end
    if (st) chk("hold_timeout", 64'(st), 64'(0));
  endtask

  task automatic idle(input int n);
    logic st;
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, st);
  endtask

  initial begin
    int          nst;
    int          r;
    logic        st;
    logic [31:0] exp_a [4];
    logic [3:0]  rop;
    logic [31:0] ra;

    resetn = 1'b0; en = 1'b1; op = 4'h0; d_address = 32'h10; d_writedata = 32'h0; mem_stalled = 1'b0;
    #3;
    chk("rst_count",   64'(sb_count), 64'(0));
    chk("rst_empty",   64'(sb_empty), 64'(1));
    chk("rst_mem_en",  64'(mem_en),   64'(0));
    chk("rst_stalled", 64'(stalled),  64'(0));
    chk("rst_mem_addr", 64'(mem_address), 64'(0));
    @(negedge clk); resetn = 1'b1; en = 1'b0;

    // Single store, then drained on the following idle cycle.
    issue(1'b1, 4'b1000, 32'h10, 32'hDEADBEEF, 1'b0, nst);
    chk("t1_stall", 64'(nst), 64'(0));
    idle(1);
    chk("t1_drain_en",   64'(o_en),   64'(1));
    chk("t1_drain_op",   64'(o_op),   64'(4'b1000));
    chk("t1_drain_addr", 64'(o_addr), 64'(32'h10));
    chk("t1_drain_data", 64'(o_wd),   64'(32'hDEADBEEF));
    idle(1);
    chk("t1_empty", 64'(sb_empty), 64'(1));

    // Five back-to-back stores; the fifth waits one cycle for the head to drain.
    exp_a[0] = 32'h4; exp_a[1] = 32'h8; exp_a[2] = 32'hC; exp_a[3] = 32'h20;
    issue(1'b1, 4'b1000, 32'h0, 32'h100, 1'b0, nst); chk("t2_s0", 64'(nst), 64'(0));
    issue(1'b1, 4'b1000, 32'h4, 32'h104, 1'b0, nst); chk("t2_s1", 64'(nst), 64'(0));
    issue(1'b1, 4'b1000, 32'h8, 32'h108, 1'b0, nst); chk("t2_s2", 64'(nst), 64'(0));
    issue(1'b1, 4'b1000, 32'hC, 32'h10C, 1'b0, nst); chk("t2_s3", 64'(nst), 64'(0));
    issue(1'b1, 4'b1000, 32'h20, 32'h120, 1'b0, nst);
    chk("t2_s4_stall", 64'(nst), 64'(1));
    chk("t2_s4_drain", 64'(f_addr), 64'(32'h0));
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("t2_order", 64'(o_addr), 64'(exp_a[i]));
    end
    idle(1);

    // Byte store followed by a load of the same word.
    issue(1'b1, 4'b1011, 32'h21, 32'hAA, 1'b0, nst);
    issue(1'b1, 4'b0000, 32'h20, 32'h0, 1'b0, nst);
    chk("t3_stall",      64'(nst),    64'(1));
    chk("t3_drain_op",   64'(f_op),   64'(4'b1011));
    chk("t3_drain_addr", 64'(f_addr), 64'(32'h21));
    chk("t3_load_op",    64'(o_op),   64'(4'b0000));
    chk("t3_load_addr",  64'(o_addr), 64'(32'h20));

    // Non-hazard load with a data_mem stall cycle: no drain during either cycle.
    issue(1'b1, 4'b1000, 32'h40, 32'h1, 1'b0, nst);
    issue(1'b1, 4'b1000, 32'h50, 32'h2, 1'b0, nst);
    issue(1'b1, 4'b0000, 32'h60, 32'h0, 1'b1, nst);
    chk("t4_memstall", 64'(nst), 64'(1));
    chk("t4_load_addr", 64'(o_addr), 64'(32'h60));
    @(negedge clk);
    chk("t4_count", 64'(sb_count), 64'(2));
    idle(3);

    // Async reset in the middle of a drain.
    for (int i = 0; i < 4; i++) issue(1'b1, 4'b1000, 32'h80 + 32'(4*i), 32'(i), 1'b0, nst);
    idle(1);
    @(negedge clk);
    en = 1'b0; #2;
    chk("t5_draining", 64'(mem_en), 64'(1));
    resetn = 1'b0; #1;
    chk("t5_count",  64'(sb_count), 64'(0));
    chk("t5_empty",  64'(sb_empty), 64'(1));
    chk("t5_mem_en", 64'(mem_en),   64'(0));
    q.delete();
    @(negedge clk); resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("t5_stale", 64'(o_en), 64'(0));
    end

    // Tail wraps, then a load matching the youngest entry waits for all four drains.
    for (int i = 0; i < 3; i++) issue(1'b1, 4'b1000, 32'h100 + 32'(4*i), 32'(i), 1'b0, nst);
    idle(3);
    for (int i = 0; i < 4; i++) issue(1'b1, 4'b1000, 32'h200 + 32'(4*i), 32'(i + 8), 1'b0, nst);
    issue(1'b1, 4'b0000, 32'h20C, 32'h0, 1'b0, nst);
    chk("t6_stall", 64'(nst), 64'(4));
    chk("t6_first_drain", 64'(f_addr), 64'(32'h200));
    chk("t6_load_en", 64'(o_en), 64'(1));
    chk("t6_load_addr", 64'(o_addr), 64'(32'h20C));

    // Random traffic over a small address window to provoke hazards.
    for (int n = 0; n < 1500; n++) begin
      r  = int'($urandom_range(0, 9));
      ra = 32'($urandom_range(0, 63));
      if (r < 3) begin
        cyc(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, st);
      end else if (r < 6) begin
        rop = {2'b10, 2'($urandom_range(0, 3))};
        issue(1'b1, rop, ra, $urandom, 1'b0, nst);
      end else begin
        rop = {1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
        issue(1'b1, rop, ra, 32'h0, ($urandom_range(0, 3) == 0), nst);
      end
    end
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
